// File: rtl/som_comutador_pkg.sv
// ----------------------------------------------------------------------------
// som_comutador_pkg
//   Shared definitions for the speaker source switcher: source codes, FSM
//   state encodings and the grant encoder used by the input stage. The
//   priority selector bench imports the same source codes.
// ----------------------------------------------------------------------------
package som_comutador_pkg;

    // Speaker source codes as seen on src_o.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'b00,
        SRC_TV    = 2'b01,
        SRC_PC    = 2'b10,
        SRC_ALEXA = 2'b11
    } src_t;

    // Output FSM states.
    typedef enum logic [1:0] {
        ST_SILENT = 2'b00,
        ST_GAP    = 2'b01,
        ST_PLAY   = 2'b10
    } state_t;

    // Encoded view of the three grant lines.
    typedef struct packed {
        src_t code;   // source code when at most one grant is high
        logic multi;  // two or more grants high at once
    } grant_t;

    // Turns the one-hot grant lines into a source code and flags a broken
    // one-hot pattern. The code is only meaningful when multi is low.
    function automatic grant_t encode_grant(input logic tv, input logic pc, input logic alexa);
        grant_t g;
        g.multi = (tv & pc) | (tv & alexa) | (pc & alexa);
        if (tv) begin
            g.code = SRC_TV;
        end else if (pc) begin
            g.code = SRC_PC;
        end else if (alexa) begin
            g.code = SRC_ALEXA;
        end else begin
            g.code = SRC_NONE;
        end
        return g;
    endfunction

endpackage

// File: rtl/som_contador_tempo.sv
// ----------------------------------------------------------------------------
// som_contador_tempo
//   CW-bit up-counter shared by the hold and gap phases of the switcher.
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous reset, active low (count -> 0)
//     clr    in   synchronous clear, wins over enable
//     en     in   count enable
//     lim    in   saturation limit; the count never passes this value
//     q      out  current count
// ----------------------------------------------------------------------------
module som_contador_tempo #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] lim,
    output logic [CW-1:0] q
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != lim)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/som_comutador.sv
// ----------------------------------------------------------------------------
// som_comutador
//   Output stage after the sound priority selector. Takes the one-hot grant
//   (TV, PC, ALEXA) and drives the speaker source select, guaranteeing a
//   minimum play time per source and a muted gap on every change.
//
//   Stage 1 registers the encoded grant into req_q (a multi-grant cycle keeps
//   req_q and pulses err_o). Stage 2 is a SILENT/GAP/PLAY FSM with all
//   outputs registered; one shared timer serves both the gap and the hold.
//
//   Optional feature: define SOM_CONTADOR_EN to add the cnt_o switch counter.
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous reset, active low
//     tv_i      in   grant to TV
//     pc_i      in   grant to PC
//     alexa_i   in   grant to ALEXA
//     src_o     out  active source: 00 none, 01 TV, 10 PC, 11 ALEXA
//     mute_o    out  speaker mute, 1 = muted
//     switch_o  out  one-cycle pulse when src_o takes a new non-none value
//     err_o     out  one-cycle pulse after a cycle with more than one grant
//     cnt_o     out  saturating switch counter (SOM_CONTADOR_EN only)
// ----------------------------------------------------------------------------
module som_comutador
    import som_comutador_pkg::*;
#(
    parameter int HOLD_CYC = 8,
    parameter int GAP_CYC  = 4,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tv_i,
    input  logic       pc_i,
    input  logic       alexa_i,
    output logic [1:0] src_o,
    output logic       mute_o,
    output logic       switch_o,
    output logic       err_o
`ifdef SOM_CONTADOR_EN
    ,
    output logic [7:0] cnt_o
`endif
);

    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_CYC - 1);

    // ------------------------------------------------------------------
    // Stage 1: grant encoding and request register
    // ------------------------------------------------------------------
    grant_t grant;
    src_t   req_q;

    assign grant = encode_grant(tv_i, pc_i, alexa_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= SRC_NONE;
            err_o <= 1'b0;
        end else begin
            err_o <= grant.multi;
            // An illegal multi-grant cycle is ignored rather than guessed at.
            if (!grant.multi) begin
                req_q <= grant.code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared phase timer
    // ------------------------------------------------------------------
    logic          tmr_clr;
    logic          tmr_en;
    logic [CW-1:0] tmr_lim;
    logic [CW-1:0] tmr_q;

    som_contador_tempo #(
        .CW (CW)
    ) u_tempo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .lim   (tmr_lim),
        .q     (tmr_q)
    );

    // ------------------------------------------------------------------
    // Stage 2: output FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    src_t   src_q, src_d;
    logic   mute_q, mute_d;
    logic   switch_q, switch_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SILENT;
            src_q    <= SRC_NONE;
            mute_q   <= 1'b1;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            mute_q   <= mute_d;
            switch_q <= switch_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        mute_d   = mute_q;
        switch_d = 1'b0;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        tmr_lim  = GAP_LIM;

        unique case (state_q)
            ST_SILENT: begin
                mute_d  = 1'b1;
                src_d   = SRC_NONE;
                // Keep the timer at zero so GAP starts counting from 0.
                tmr_clr = 1'b1;
                if (req_q != SRC_NONE) begin
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                mute_d  = 1'b1;
                tmr_lim = GAP_LIM;
                if (tmr_q == GAP_LIM) begin
                    // Only the request present at the end of the gap counts.
                    tmr_clr = 1'b1;
                    if (req_q == SRC_NONE) begin
                        state_d = ST_SILENT;
                        src_d   = SRC_NONE;
                    end else begin
                        state_d  = ST_PLAY;
                        src_d    = req_q;
                        mute_d   = 1'b0;
                        switch_d = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_PLAY: begin
                mute_d  = 1'b0;
                tmr_lim = HOLD_LIM;
                // A differing request waits here until the hold expires; if
                // it reverts to src_q in the meantime nothing happens.
                if ((req_q != src_q) && (tmr_q == HOLD_LIM)) begin
                    state_d = ST_GAP;
                    mute_d  = 1'b1;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_SILENT;
                src_d   = SRC_NONE;
                mute_d  = 1'b1;
                tmr_clr = 1'b1;
            end
        endcase
    end

    assign src_o    = src_q;
    assign mute_o   = mute_q;
    assign switch_o = switch_q;

`ifdef SOM_CONTADOR_EN
    // ------------------------------------------------------------------
    // Optional saturating switch counter
    // ------------------------------------------------------------------
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (switch_q && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule
